// File: rtl/vga_framebuffer_reader.sv
`timescale 1ns/1ps
// Read side of the 16x12-cell, 3-bit colour VGA frame buffer: generates 640x480@60 timing
// from the system clock, scans the buffer in raster order and drives aligned colour/sync pins.
module vga_framebuffer_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CELL_W    = 40,
  parameter int unsigned CELL_H    = 40
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] oReadAddress,
  input  logic [2:0] iReadData,
  output logic       VGA_RED,
  output logic       VGA_BLUE,
  output logic       VGA_GREEN,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       oFrameStart
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned SxW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned SyW    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int unsigned Cols   = H_VISIBLE / CELL_W;
  localparam int unsigned Rows   = V_VISIBLE / CELL_H;

  localparam logic [HW-1:0]  HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0]  HVis    = HW'(H_VISIBLE);
  localparam logic [HW-1:0]  HsFirst = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0]  HsLast  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0]  VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0]  VVis    = VW'(V_VISIBLE);
  localparam logic [VW-1:0]  VsFirst = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0]  VsLast  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [SxW-1:0] SxLast  = SxW'(CELL_W - 1);
  localparam logic [SyW-1:0] SyLast  = SyW'(CELL_H - 1);
  localparam logic [3:0]     ColLast = 4'(Cols - 1);
  localparam logic [3:0]     RowLast = 4'(Rows - 1);

  logic           pix_en_q, pix_en_d;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [SxW-1:0] sub_x_q, sub_x_d;
  logic [SyW-1:0] sub_y_q, sub_y_d;
  logic [3:0]     col_q, col_d;
  logic [3:0]     row_q, row_d;
  logic [7:0]     addr_q, addr_d;
  // First stage: timing flags for the pixel whose address was just issued.
  logic           vis_q, vis_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  // Second stage: pin registers, aligned with the colour returned by the RAM.
  logic           hs_out_q, hs_out_d;
  logic           vs_out_q, vs_out_d;
  logic [2:0]     rgb_q, rgb_d;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    sub_x_d  = sub_x_q;
    sub_y_d  = sub_y_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    vis_d    = vis_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    hs_out_d = hs_out_q;
    vs_out_d = vs_out_q;
    rgb_d    = rgb_q;

    if (pix_en_q) begin
      addr_d   = {row_q, col_q};
      vis_d    = (h_q < HVis) && (v_q < VVis);
      hs_d     = ~((h_q >= HsFirst) && (h_q <= HsLast));
      vs_d     = ~((v_q >= VsFirst) && (v_q <= VsLast));
      hs_out_d = hs_q;
      vs_out_d = vs_q;
      rgb_d    = vis_q ? iReadData : 3'b000;

      if (h_q == HLast) begin
        h_d     = '0;
        sub_x_d = '0;
        col_d   = '0;
        if (v_q == VLast) begin
          v_d     = '0;
          sub_y_d = '0;
          row_d   = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (v_q < VVis) begin
            if (sub_y_q == SyLast) begin
              sub_y_d = '0;
              if (row_q != RowLast) row_d = row_q + 1'b1;
            end else begin
              sub_y_d = sub_y_q + 1'b1;
            end
          end
        end
      end else begin
        h_d = h_q + 1'b1;
        if (h_q < HVis) begin
          // Column saturates on the last cell so the address stays inside the buffer.
          if (sub_x_q == SxLast) begin
            sub_x_d = '0;
            if (col_q != ColLast) col_d = col_q + 1'b1;
          end else begin
            sub_x_d = sub_x_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      sub_x_q  <= '0;
      sub_y_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      vis_q    <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
      rgb_q    <= 3'b000;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      sub_x_q  <= sub_x_d;
      sub_y_q  <= sub_y_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      vis_q    <= vis_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hs_out_q <= hs_out_d;
      vs_out_q <= vs_out_d;
      rgb_q    <= rgb_d;
    end
  end

  assign oReadAddress = addr_q;
  assign VGA_RED      = rgb_q[2];
  assign VGA_BLUE     = rgb_q[1];
  assign VGA_GREEN    = rgb_q[0];
  assign VGA_HS       = hs_out_q;
  assign VGA_VS       = vs_out_q;
  assign oFrameStart  = pix_en_q && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
`timescale 1ns/1ps
// Bench for vga_framebuffer_reader with a shortened vertical frame (24 visible lines, 2-line
// cells) so full frames fit in a short run; horizontal timing keeps its real values.
module tb_vga_framebuffer_reader;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] oReadAddress;
  logic [2:0] iReadData;
  logic       VGA_RED, VGA_BLUE, VGA_GREEN, VGA_HS, VGA_VS, oFrameStart;
  logic       force_white = 1'b0;

  vga_framebuffer_reader #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(24),  .V_FRONT(2),  .V_SYNC(2),  .V_BACK(2),
    .CELL_W(40),     .CELL_H(2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .oReadAddress(oReadAddress),
    .iReadData   (iReadData),
    .VGA_RED     (VGA_RED),
    .VGA_BLUE    (VGA_BLUE),
    .VGA_GREEN   (VGA_GREEN),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .oFrameStart (oFrameStart)
  );

  initial forever #5 Clock = ~Clock;

  // RAM model: colour = addr[2:0], except address 0 holds 3'b011.
  assign iReadData = force_white ? 3'b111 :
                     (oReadAddress == 8'd0) ? 3'b011 : oReadAddress[2:0];

  typedef enum int {SigAddr, SigRgb, SigHs, SigVs, SigFs, SigMaxAddr, SigFsCount, SigFsAdj} sig_e;
  typedef struct {
    int    epoch;
    int    t;
    sig_e  sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   epoch = 0;
  int   t = 0;
  bit   in_rst = 1'b0;
  int   max_addr = 0;
  int   fs_count = 0;
  int   fs_adj = 0;
  bit   fs_prev = 1'b0;

  task automatic push(input int ep, input int tt, input sig_e s, input int v, input string nm);
    exp_t e;
    e.epoch = ep;
    e.t     = tt;
    e.sig   = s;
    e.exp   = v;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  function automatic int sample(input sig_e s);
    case (s)
      SigAddr:    return int'(oReadAddress);
      SigRgb:     return int'({VGA_RED, VGA_BLUE, VGA_GREEN});
      SigHs:      return int'(VGA_HS);
      SigVs:      return int'(VGA_VS);
      SigFs:      return int'(oFrameStart);
      SigMaxAddr: return max_addr;
      SigFsCount: return fs_count;
      SigFsAdj:   return fs_adj;
      default:    return -1;
    endcase
  endfunction

  // Clock index since the most recent reset release; epoch counts reset assertions.
  initial forever begin
    @(posedge Clock);
    if (!Reset) begin
      if (!in_rst) epoch = epoch + 1;
      in_rst = 1'b1;
      t = 0;
    end else begin
      in_rst = 1'b0;
      t = t + 1;
    end
  end

  // Monitor: samples the pins every clock and retires any expectation due now.
  initial begin
    exp_t keep[$];
    int   got;
    forever begin
      @(negedge Clock);
      if (int'(oReadAddress) > max_addr) max_addr = int'(oReadAddress);
      if (oFrameStart) fs_count++;
      if (oFrameStart && fs_prev) fs_adj++;
      fs_prev = oFrameStart;
      keep = {};
      foreach (sb_q[i]) begin
        if (sb_q[i].epoch == epoch && sb_q[i].t == t) begin
          got = sample(sb_q[i].sig);
          n_cmp++;
          if (got != sb_q[i].exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (epoch %0d, t=%0d)",
                     sb_q[i].name, got, sb_q[i].exp, epoch, t);
          end
        end else if (sb_q[i].epoch < epoch || (sb_q[i].epoch == epoch && sb_q[i].t < t)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: never sampled, expected %0d (epoch %0d, t=%0d)",
                   sb_q[i].name, sb_q[i].exp, sb_q[i].epoch, sb_q[i].t);
        end else begin
          keep.push_back(sb_q[i]);
        end
      end
      sb_q = keep;
    end
  end

  initial begin
    // Epoch 1: power-up reset, first line, cell stepping, blanking, HS timing.
    push(1, 0, SigAddr, 0, "rst_addr");
    push(1, 0, SigRgb, 0, "rst_rgb");
    push(1, 0, SigHs, 1, "rst_hs");
    push(1, 0, SigVs, 1, "rst_vs");
    push(1, 0, SigFs, 0, "rst_fs");
    push(1, 1, SigFs, 1, "fs_first_tick");
    push(1, 2, SigFs, 0, "fs_drop");
    push(1, 2, SigAddr, 0, "addr_pix0");
    push(1, 3, SigRgb, 0, "rgb_before_pix0");
    push(1, 4, SigRgb, 3, "rgb_pix0");
    push(1, 81, SigAddr, 0, "addr_pix39");
    push(1, 82, SigAddr, 1, "addr_pix40");
    push(1, 83, SigRgb, 3, "rgb_pix39");
    push(1, 84, SigRgb, 1, "rgb_pix40");
    push(1, 1282, SigRgb, 7, "rgb_pix639");
    push(1, 1284, SigRgb, 0, "rgb_pix640_blank");
    push(1, 1315, SigHs, 1, "hs_before_pulse");
    push(1, 1316, SigHs, 0, "hs_pulse_start");
    push(1, 1507, SigHs, 0, "hs_pulse_end");
    push(1, 1508, SigHs, 1, "hs_after_pulse");
    push(1, 1599, SigRgb, 0, "rgb_pix797_blank");
    push(1, 1602, SigAddr, 0, "addr_line1");
    push(1, 1604, SigRgb, 3, "rgb_line1_pix0");
    push(1, 2915, SigHs, 1, "hs2_before_pulse");
    push(1, 2916, SigHs, 0, "hs2_pulse_start");
    push(1, 3202, SigAddr, 16, "addr_row1");
    push(1, 3282, SigAddr, 17, "addr_row1_col1");
    push(1, 8602, SigAddr, 39, "addr_mid_frame");
    push(1, 8602, SigRgb, 7, "rgb_mid_frame");
    push(1, 8602, SigVs, 1, "vs_mid_frame");

    Reset = 1'b0;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (1282) @(negedge Clock);
    force_white = 1'b1;
    repeat (308) @(negedge Clock);
    force_white = 1'b0;
    repeat (8602 - 1590) @(negedge Clock);

    // Epoch 2: reset pulse at h=300, v=5, then a complete frame.
    push(2, 0, SigAddr, 0, "mid_rst_addr");
    push(2, 0, SigRgb, 0, "mid_rst_rgb");
    push(2, 0, SigHs, 1, "mid_rst_hs");
    push(2, 0, SigVs, 1, "mid_rst_vs");
    push(2, 0, SigFs, 0, "mid_rst_fs");
    push(2, 1, SigFs, 1, "restart_fs");
    push(2, 2, SigAddr, 0, "restart_addr");
    push(2, 4, SigRgb, 3, "restart_rgb");
    push(2, 1315, SigHs, 1, "restart_hs_before");
    push(2, 1316, SigHs, 0, "restart_hs_low");
    push(2, 38000, SigAddr, 190, "addr_last_line_col14");
    push(2, 38002, SigAddr, 191, "addr_last_cell");
    push(2, 38004, SigRgb, 7, "rgb_last_cell");
    push(2, 41603, SigVs, 1, "vs_before_pulse");
    push(2, 41604, SigVs, 0, "vs_pulse_start");
    push(2, 44803, SigVs, 0, "vs_pulse_end");
    push(2, 44804, SigVs, 1, "vs_after_pulse");
    push(2, 48000, SigFs, 0, "fs_frame2_before");
    push(2, 48001, SigFs, 1, "fs_frame2");
    push(2, 48002, SigFs, 0, "fs_frame2_after");
    push(2, 48002, SigAddr, 0, "addr_frame2");
    push(2, 48004, SigRgb, 3, "rgb_frame2_pix0");
    push(2, 48006, SigMaxAddr, 191, "max_addr");
    push(2, 48006, SigFsCount, 3, "frame_start_count");
    push(2, 48006, SigFsAdj, 0, "frame_start_adjacent");

    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (48010) @(negedge Clock);
    @(posedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
